// File: rtl/aes_kat_checker.sv
`default_nettype none
// ============================================================================
// Module   : aes_kat_checker
// Purpose  : Runs one AES known-answer test against an external AES core.
//            A run latches key/plaintext/golden cipher, launches the core,
//            waits (bounded by TIMEOUT) for its result, compares the
//            ciphertext and the round-trip decryption, and reports a verdict
//            with saturating pass/fail tallies.
// Ports    : clk, rst                  - clock, async active-high reset
//            start_i                   - request a run (honoured in IDLE only)
//            key_i, plain_text_i,
//            expected_cipher_i         - run vectors, latched at start
//            aes_start_o               - one-cycle launch pulse to the core
//            aes_key_o, aes_plain_text_o - latched vectors to the core
//            aes_done_i, cipher_text_i,
//            decrypted_plain_text_i    - core result strobe and data
//            busy_o, done_o            - activity / one-cycle verdict pulse
//            pass_o, fail_cipher_o, fail_decrypt_o, timed_out_o - verdict
//            pass_count_o, fail_count_o - saturating run tallies
// Revision : 1.0 - initial release
// ============================================================================
module aes_kat_checker #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] plain_text_i,
    input  logic [127:0] expected_cipher_i,
    output logic         aes_start_o,
    output logic [127:0] aes_key_o,
    output logic [127:0] aes_plain_text_o,
    input  logic         aes_done_i,
    input  logic [127:0] cipher_text_i,
    input  logic [127:0] decrypted_plain_text_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic         fail_cipher_o,
    output logic         fail_decrypt_o,
    output logic         timed_out_o,
    output logic [7:0]   pass_count_o,
    output logic [7:0]   fail_count_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    // Last timer value that is still a legal WAIT cycle.
    localparam logic [7:0] C_TIMER_LAST = 8'(TIMEOUT - 1);

    state_t       state_q;
    logic [7:0]   timer_q;
    logic [127:0] key_q;
    logic [127:0] plain_q;
    logic [127:0] expected_q;
    logic [127:0] cipher_q;
    logic [127:0] decrypted_q;
    logic         aes_start_q;
    logic         busy_q;
    logic         done_q;
    logic         pass_q;
    logic         fail_cipher_q;
    logic         fail_decrypt_q;
    logic         timed_out_q;
    logic [7:0]   pass_count_q;
    logic [7:0]   fail_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= 8'd0;
            key_q          <= 128'd0;
            plain_q        <= 128'd0;
            expected_q     <= 128'd0;
            cipher_q       <= 128'd0;
            decrypted_q    <= 128'd0;
            aes_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_cipher_q  <= 1'b0;
            fail_decrypt_q <= 1'b0;
            timed_out_q    <= 1'b0;
            pass_count_q   <= 8'd0;
            fail_count_q   <= 8'd0;
        end else begin
            // Pulsed outputs default low; they are raised on the transition
            // into the state they belong to so they are visible in that state.
            aes_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        key_q       <= key_i;
                        plain_q     <= plain_text_i;
                        expected_q  <= expected_cipher_i;
                        aes_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    pass_q         <= 1'b0;
                    fail_cipher_q  <= 1'b0;
                    fail_decrypt_q <= 1'b0;
                    timed_out_q    <= 1'b0;
                    timer_q        <= 8'd0;
                    state_q        <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final timer cycle beats the timeout.
                    if (aes_done_i) begin
                        cipher_q    <= cipher_text_i;
                        decrypted_q <= decrypted_plain_text_i;
                        state_q     <= S_CHECK;
                    end else if (timer_q == C_TIMER_LAST) begin
                        timed_out_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_REPORT;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_CHECK: begin
                    fail_cipher_q  <= (cipher_q != expected_q);
                    fail_decrypt_q <= (decrypted_q != plain_q);
                    pass_q         <= (cipher_q == expected_q) && (decrypted_q == plain_q);
                    done_q         <= 1'b1;
                    state_q        <= S_REPORT;
                end
                S_REPORT: begin
                    if (pass_q) begin
                        if (pass_count_q != 8'hFF) begin
                            pass_count_q <= pass_count_q + 8'd1;
                        end
                    end else if (fail_count_q != 8'hFF) begin
                        fail_count_q <= fail_count_q + 8'd1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign aes_start_o      = aes_start_q;
    assign aes_key_o        = key_q;
    assign aes_plain_text_o = plain_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_cipher_o    = fail_cipher_q;
    assign fail_decrypt_o   = fail_decrypt_q;
    assign timed_out_o      = timed_out_q;
    assign pass_count_o     = pass_count_q;
    assign fail_count_o     = fail_count_q;

endmodule
`default_nettype wire
